// File: rtl/pipeline_debug_pkg.sv
// Shared definitions for the pipeline run-control / state-dump unit.
// Optional feature macro: DEBUG_CHECKSUM_EN (appends an XOR checksum byte to each dump frame).
package pipeline_debug_pkg;

  localparam logic [7:0] CMD_RUN      = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP     = 8'h73;  // 's'
  localparam logic [7:0] CMD_DUMP     = 8'h64;  // 'd'
  localparam logic [7:0] FRAME_HEADER = 8'hA5;

  localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'b111111;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    CAPTURE,
    SEND
  } state_t;

endpackage

// File: rtl/pipeline_debug_unit_serializer.sv
// debug_serializer: shadow copy of the pipeline snapshot plus the byte-wise
// valid/ready streamer that sends the dump frame.
// Optional feature macro: DEBUG_CHECKSUM_EN (trailing XOR byte).
module debug_serializer
  import pipeline_debug_pkg::*;
#(
  parameter int NUM_WORDS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [31:0]            cycle_cnt,
  input  logic [32*NUM_WORDS-1:0] snap_bus,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  output logic                   done
);

  localparam int DATA_LEN = 5 + 4 * NUM_WORDS;
`ifdef DEBUG_CHECKSUM_EN
  localparam int FRAME_LEN = DATA_LEN + 1;
`else
  localparam int FRAME_LEN = DATA_LEN;
`endif
  localparam int IDX_W = $clog2(FRAME_LEN);

  logic [32*NUM_WORDS-1:0] snap_shadow;
  logic [31:0]             cnt_shadow;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        next_idx;
  logic [7:0]              next_byte;
  logic [8*DATA_LEN-1:0]   frame_bits;
  logic                    accept;
  logic                    last;
`ifdef DEBUG_CHECKSUM_EN
  logic [7:0]              csum;
`endif

  // Snapshot words are already LSB-first bytes, so the frame is one flat vector.
  assign frame_bits = {snap_shadow, cnt_shadow, FRAME_HEADER};
  assign accept     = tx_valid && tx_ready;
  assign last       = (idx == IDX_W'(FRAME_LEN - 1));
  assign done       = accept && last;
  assign next_idx   = idx + 1'b1;

  // Select the byte that follows the one currently on tx_data.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_byte unassigned (no latch).
    next_byte = frame_bits[{next_idx, 3'b000} +: 8];
`ifdef DEBUG_CHECKSUM_EN
    if (next_idx == IDX_W'(DATA_LEN)) next_byte = csum ^ tx_data;
`endif
  end

  // Load the shadow copy on the capture pulse, then step through the frame on each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow registers are ordinary flops, not a RAM, so they take a reset value.
      snap_shadow <= '0;
      cnt_shadow  <= '0;
      idx         <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
`ifdef DEBUG_CHECKSUM_EN
      csum        <= 8'h00;
`endif
    end else if (load) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      snap_shadow <= snap_bus;
      cnt_shadow  <= cycle_cnt;
      idx         <= '0;
      tx_valid    <= 1'b1;
      tx_data     <= FRAME_HEADER;
`ifdef DEBUG_CHECKSUM_EN
      csum        <= 8'h00;
`endif
    end else if (accept) begin
`ifdef DEBUG_CHECKSUM_EN
      csum <= csum ^ tx_data;
`endif
      if (last) begin
        idx      <= '0;
        tx_valid <= 1'b0;
        tx_data  <= 8'h00;
      end else begin
        idx     <= next_idx;
        tx_data <= next_byte;
      end
    end
  end

endmodule

// File: rtl/pipeline_debug_unit.sv
// pipeline_debug_unit: run/step/dump control for the five-stage MIPS pipeline.
// Gates the pipeline via pipe_en, counts enabled cycles, and dumps a snapshot over UART.
// Optional feature macro: DEBUG_CHECKSUM_EN (handled inside debug_serializer).
module pipeline_debug_unit
  import pipeline_debug_pkg::*;
#(
  parameter int         NUM_WORDS   = 8,
  parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic [31:0]             instruction_IF,
  input  logic [32*NUM_WORDS-1:0] snap_bus,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    pipe_en,
  output logic                    halted,
  output logic                    busy
);

  state_t      state;
  logic [31:0] cycle_cnt;
  logic        ser_done;
  logic        load;
  logic        halt_hit;
  logic        unused_ok;

  assign pipe_en   = (state == RUN) || (state == STEP);
  assign busy      = (state != IDLE);
  assign load      = (state == CAPTURE);
  assign halt_hit  = (instruction_IF[31:26] == HALT_OPCODE);
  assign unused_ok = ^instruction_IF[25:0];

  // Run-control FSM, sticky halt flag and enabled-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      halted    <= 1'b0;
      cycle_cnt <= 32'h0;
    end else begin
      if (pipe_en) cycle_cnt <= cycle_cnt + 32'd1;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_RUN && !halted)       state <= RUN;
            else if (rx_data == CMD_STEP && !halted) state <= STEP;
            else if (rx_data == CMD_DUMP)            state <= CAPTURE;
          end
        end
        RUN: begin
          if (halt_hit) begin
            state  <= CAPTURE;
            halted <= 1'b1;
          end
        end
        STEP:    state <= CAPTURE;
        CAPTURE: state <= SEND;
        SEND:    if (ser_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  debug_serializer #(
    .NUM_WORDS (NUM_WORDS)
  ) u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .cycle_cnt (cycle_cnt),
    .snap_bus  (snap_bus),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_pipeline_debug_unit.sv
// Self-checking bench for pipeline_debug_unit: command vectors table plus reset-abort sequence.
module tb_pipeline_debug_unit;
  import pipeline_debug_pkg::*;

  localparam int NW = 2;
`ifdef DEBUG_CHECKSUM_EN
  localparam int FRAME_LEN = 6 + 4 * NW;
`else
  localparam int FRAME_LEN = 5 + 4 * NW;
`endif
  localparam logic [31:0] HALT_INSTR = {6'b111111, 26'h0};

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic [31:0]     instruction_IF;
  logic [32*NW-1:0] snap_bus;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            pipe_en;
  logic            halted;
  logic            busy;

  int n_cmp  = 0;
  int n_fail = 0;

  pipeline_debug_unit #(
    .NUM_WORDS   (NW),
    .HALT_OPCODE (6'b111111)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .instruction_IF (instruction_IF),
    .snap_bus       (snap_bus),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .pipe_en        (pipe_en),
    .halted         (halted),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          halt_on_cmd;
    int          halt_at;
    int          stall_at;
    int          inject_at;
    int          exp_pulses;
    logic [31:0] exp_cnt;
    bit          exp_halted;
    bit          has_frame;
    int          exp_first;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one command, watch pipe_en and the resulting frame, compare against the vector.
  task automatic run_entry(input vec_t v, input int id);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] hold;
    logic [7:0] x;
    int pulses = 0;
    int first  = -1;
    int gaps   = 0;
    int k      = 0;
    bit stalled  = 1'b0;
    bit injected = 1'b0;

    snap_bus       = {v.w1, v.w0};
    instruction_IF = v.halt_on_cmd ? HALT_INSTR : 32'h0;
    rx_data        = v.cmd;
    rx_valid       = 1'b1;
    tick();
    rx_valid       = 1'b0;
    instruction_IF = 32'h0;

    while (busy && k < 200) begin
      rx_valid = 1'b0;
      if (pipe_en) pulses++;
      instruction_IF = (pipe_en && pulses == v.halt_at) ? HALT_INSTR : 32'h0;
      if (tx_valid) begin
        if (first < 0) first = k;
        if (!stalled && int'(got_q.size()) == v.stall_at) begin
          stalled  = 1'b1;
          hold     = tx_data;
          tx_ready = 1'b0;
          repeat (5) begin
            tick();
            k++;
            check($sformatf("v%0d stall tx_data", id), {24'h0, tx_data}, {24'h0, hold});
            check($sformatf("v%0d stall tx_valid", id), {31'h0, tx_valid}, 32'h1);
          end
          tx_ready = 1'b1;
        end
        if (!injected && int'(got_q.size()) == v.inject_at) begin
          injected = 1'b1;
          rx_data  = CMD_STEP;
          rx_valid = 1'b1;
        end
        got_q.push_back(tx_data);
      end else if (first >= 0) begin
        gaps++;
      end
      tick();
      k++;
    end
    rx_valid       = 1'b0;
    instruction_IF = 32'h0;
    if (k >= 200) check($sformatf("v%0d timeout busy", id), {31'h0, busy}, 32'h0);

    if (v.has_frame) begin
      exp_q.push_back(FRAME_HEADER);
      for (int b = 0; b < 4; b++) exp_q.push_back(8'((v.exp_cnt >> (8 * b)) & 32'hFF));
      for (int b = 0; b < 4; b++) exp_q.push_back(8'((v.w0 >> (8 * b)) & 32'hFF));
      for (int b = 0; b < 4; b++) exp_q.push_back(8'((v.w1 >> (8 * b)) & 32'hFF));
`ifdef DEBUG_CHECKSUM_EN
      x = 8'h00;
      foreach (exp_q[i]) x = x ^ exp_q[i];
      exp_q.push_back(x);
`endif
    end

    check($sformatf("v%0d pipe_en pulses", id), pulses, v.exp_pulses);
    check($sformatf("v%0d frame length", id), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("v%0d byte %0d", id, i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
    check($sformatf("v%0d halted", id), {31'h0, halted}, {31'h0, v.exp_halted});
    check($sformatf("v%0d tx_valid gaps", id), gaps, 0);
    if (v.exp_first >= 0)
      check($sformatf("v%0d first byte latency", id), first, v.exp_first);
  endtask

  initial begin
    vec_t rv;

    //          cmd       w0            w1            hoc h_at stall inject          pul cnt    hlt frm first
    vecs[0] = '{CMD_DUMP, 32'h11223344, 32'hCAFEF00D, 0,  0,   3,    -1,             0,  32'd0,  0,  1,  1};
    vecs[1] = '{CMD_STEP, 32'hDEADBEEF, 32'h01020304, 0,  0,   -1,   -1,             1,  32'd1,  0,  1,  2};
    vecs[2] = '{CMD_STEP, 32'h0000FFFF, 32'h80000001, 0,  0,   -1,   -1,             1,  32'd2,  0,  1,  2};
    vecs[3] = '{8'h78,    32'h0,        32'h0,        0,  0,   -1,   -1,             0,  32'd2,  0,  0,  -1};
    vecs[4] = '{CMD_DUMP, 32'hA5A5A5A5, 32'h5A5A5A5A, 0,  0,   -1,   2,              0,  32'd2,  0,  1,  1};
    vecs[5] = '{CMD_DUMP, 32'h12345678, 32'h9ABCDEF0, 0,  0,   -1,   FRAME_LEN - 1,  0,  32'd2,  0,  1,  1};
    vecs[6] = '{CMD_RUN,  32'h00000010, 32'hFFFFFFFF, 1,  10,  -1,   -1,             10, 32'd12, 1,  1,  11};
    vecs[7] = '{CMD_STEP, 32'h0,        32'h0,        0,  0,   -1,   -1,             0,  32'd12, 1,  0,  -1};
    vecs[8] = '{CMD_RUN,  32'h0,        32'h0,        0,  0,   -1,   -1,             0,  32'd12, 1,  0,  -1};
    vecs[9] = '{CMD_DUMP, 32'h0BADC0DE, 32'h00000000, 0,  0,   -1,   -1,             0,  32'd12, 1,  1,  1};

    rst_n          = 1'b0;
    rx_data        = 8'h00;
    rx_valid       = 1'b0;
    instruction_IF = 32'h0;
    snap_bus       = '0;
    tx_ready       = 1'b1;
    #12;
    check("reset pipe_en", {31'h0, pipe_en}, 32'h0);
    check("reset halted", {31'h0, halted}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset tx_valid", {31'h0, tx_valid}, 32'h0);
    check("reset tx_data", {24'h0, tx_data}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_entry(vecs[i], i);
      tick();
    end

    // Reset in the middle of a dump aborts the frame at once.
    snap_bus = {32'h55667788, 32'h99AABBCC};
    rx_data  = CMD_DUMP;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (4) tick();
    check("pre-abort tx_valid", {31'h0, tx_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort tx_valid", {31'h0, tx_valid}, 32'h0);
    check("abort busy", {31'h0, busy}, 32'h0);
    check("abort pipe_en", {31'h0, pipe_en}, 32'h0);
    check("abort halted", {31'h0, halted}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post-abort tx_valid", {31'h0, tx_valid}, 32'h0);
    rv = '{CMD_DUMP, 32'h11223344, 32'h00C0FFEE, 0, 0, -1, -1, 0, 32'd0, 0, 1, 1};
    run_entry(rv, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
